// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-port register file for the 16-bit pipeline.
// Flop-based storage, combinational read ports, one write port.
// An optional write-to-read bypass is controlled by the BYPASS parameter.
// Compile-time option: define REGFILE_SCOREBOARD_EN to add the busy-bit
// scoreboard and the iss_valid_i/iss_dst_i/rd_busy_o/stall_o ports.
module reg_file_mp #(
  parameter int                 DATA_W    = 16,
  parameter int                 ADDR_W    = 3,
  parameter int                 NUM_RD    = 2,
  parameter bit                 ZERO_REG  = 1'b1,
  parameter bit                 BYPASS    = 1'b1,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [DATA_W-1:0]        wr_data_i
`ifdef REGFILE_SCOREBOARD_EN
  ,
  input  logic                     iss_valid_i,
  input  logic [ADDR_W-1:0]        iss_dst_i,
  output logic [NUM_RD-1:0]        rd_busy_o,
  output logic                     stall_o
`endif
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];

  // Next-state of the array: only the addressed register changes, and register 0 stays put when hardwired.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_en_i && !(ZERO_REG && (wr_addr_i == '0))) begin
      regs_d[wr_addr_i] = wr_data_i;
    end
  end

  // Storage flops; reset is asynchronous, so a write in flight during reset is lost.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= (ZERO_REG && (i == 0)) ? {DATA_W{1'b0}} : RESET_VAL;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read ports: hardwired zero first, then same-cycle bypass, then the stored value.
  always_comb begin
    rd_data_o = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (ZERO_REG && (rd_addr_i[k*ADDR_W +: ADDR_W] == '0)) begin
        rd_data_o[k*DATA_W +: DATA_W] = '0;
      end else if (BYPASS && wr_en_i && (wr_addr_i == rd_addr_i[k*ADDR_W +: ADDR_W])) begin
        rd_data_o[k*DATA_W +: DATA_W] = wr_data_i;
      end else begin
        rd_data_o[k*DATA_W +: DATA_W] = regs_q[rd_addr_i[k*ADDR_W +: ADDR_W]];
      end
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Busy-bit update: retire first, then issue, so a same-register issue overrides the retiring write.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_i) begin
      busy_d[wr_addr_i] = 1'b0;
    end
    if (iss_valid_i && !(ZERO_REG && (iss_dst_i == '0))) begin
      busy_d[iss_dst_i] = 1'b1;
    end
  end

  // Busy-bit register, cleared by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Per-port busy lookup; a write being bypassed this cycle already satisfies the reader.
  always_comb begin
    rd_busy_o = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_busy_o[k] = busy_q[rd_addr_i[k*ADDR_W +: ADDR_W]] &
                     ~(BYPASS && wr_en_i && (wr_addr_i == rd_addr_i[k*ADDR_W +: ADDR_W]));
    end
    stall_o = |rd_busy_o;
  end
`endif

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed, table-driven bench for reg_file_mp.
// dutA uses the default build (2 read ports, bypass on); dutB has 4 read ports
// and bypass off. Both share clock, reset and the write port.
module tb_reg_file_mp;

  logic        clk;
  logic        rst;
  logic        wrEn;
  logic [2:0]  wrAddr;
  logic [15:0] wrData;
  logic [5:0]  rdAddrA;
  logic [31:0] rdDataA;
  logic [11:0] rdAddrB;
  logic [63:0] rdDataB;
`ifdef REGFILE_SCOREBOARD_EN
  logic        issValid;
  logic [2:0]  issDst;
  logic [1:0]  rdBusyA;
  logic        stallA;
  logic [3:0]  rdBusyB;
  logic        stallB;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic             rst;
    logic             we;
    logic [2:0]       wa;
    logic [15:0]      wd;
    logic [3:0][2:0]  ra;
    logic [1:0][15:0] ea;
    logic [3:0][15:0] eb;
  } vec_t;

  vec_t vecs [12];

  reg_file_mp dutA (
    .clk_i     (clk),
    .rst_i     (rst),
    .rd_addr_i (rdAddrA),
    .rd_data_o (rdDataA),
    .wr_en_i   (wrEn),
    .wr_addr_i (wrAddr),
    .wr_data_i (wrData)
`ifdef REGFILE_SCOREBOARD_EN
    ,
    .iss_valid_i (issValid),
    .iss_dst_i   (issDst),
    .rd_busy_o   (rdBusyA),
    .stall_o     (stallA)
`endif
  );

  reg_file_mp #(.NUM_RD(4), .BYPASS(1'b0)) dutB (
    .clk_i     (clk),
    .rst_i     (rst),
    .rd_addr_i (rdAddrB),
    .rd_data_o (rdDataB),
    .wr_en_i   (wrEn),
    .wr_addr_i (wrAddr),
    .wr_data_i (wrData)
`ifdef REGFILE_SCOREBOARD_EN
    ,
    .iss_valid_i (issValid),
    .iss_dst_i   (issDst),
    .rd_busy_o   (rdBusyB),
    .stall_o     (stallB)
`endif
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mkVec(input logic r, input logic we, input logic [2:0] wa,
                                 input logic [15:0] wd,
                                 input logic [2:0] r0, input logic [2:0] r1,
                                 input logic [2:0] r2, input logic [2:0] r3,
                                 input logic [15:0] a0, input logic [15:0] a1,
                                 input logic [15:0] b0, input logic [15:0] b1,
                                 input logic [15:0] b2, input logic [15:0] b3);
    vec_t v;
    v.rst = r;  v.we = we;  v.wa = wa;  v.wd = wd;
    v.ra[0] = r0; v.ra[1] = r1; v.ra[2] = r2; v.ra[3] = r3;
    v.ea[0] = a0; v.ea[1] = a1;
    v.eb[0] = b0; v.eb[1] = b1; v.eb[2] = b2; v.eb[3] = b3;
    return v;
  endfunction

  // Drive one cycle's inputs on the falling edge, then let combinational paths settle.
  // Port k of dutA uses address rk (k = 0,1); dutB uses r0..r3.
  task automatic applyStimulus(input logic r, input logic we, input logic [2:0] wa,
                               input logic [15:0] wd,
                               input logic [2:0] r0, input logic [2:0] r1,
                               input logic [2:0] r2, input logic [2:0] r3);
    @(negedge clk);
    rst     = r;
    wrEn    = we;
    wrAddr  = wa;
    wrData  = wd;
    rdAddrA = {r1, r0};
    rdAddrB = {r3, r2, r1, r0};
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; wrEn = 1'b0; wrAddr = '0; wrData = '0; rdAddrA = '0; rdAddrB = '0;
`ifdef REGFILE_SCOREBOARD_EN
    issValid = 1'b0; issDst = '0;
`endif

    // Reset state
    applyStimulus(1'b1, 1'b0, 3'd0, 16'h0, 3'd1, 3'd7, 3'd0, 3'd4);
    checkOutput("reset.a", {32'h0, rdDataA}, 64'h0);
    checkOutput("reset.b", rdDataB, 64'h0);

    // Fill registers 1..7 with 0xABCD, then check the fill landed
    for (int a = 1; a < 8; a++) begin
      applyStimulus(1'b0, 1'b1, a[2:0], 16'hABCD, 3'd1, 3'd1, 3'd1, 3'd1);
    end
    applyStimulus(1'b0, 1'b0, 3'd0, 16'h0, 3'd1, 3'd7, 3'd3, 3'd5);
    checkOutput("fill.a", {32'h0, rdDataA}, {32'h0, 32'hABCD_ABCD});
    checkOutput("fill.b", rdDataB, 64'hABCD_ABCD_ABCD_ABCD);

    // Asynchronous reset mid-cycle: outputs clear before the next rising edge
    #2 rst = 1'b1;
    #1;
    checkOutput("asyncrst.a", {32'h0, rdDataA}, 64'h0);
    checkOutput("asyncrst.b", rdDataB, 64'h0);

    // Directed vector table (registers all zero on entry)
    vecs[0]  = mkVec(0, 1, 3'd3, 16'h1234, 3'd3, 3'd3, 3'd3, 3'd3, 16'h1234, 16'h1234, 16'h0, 16'h0, 16'h0, 16'h0);
    vecs[1]  = mkVec(0, 0, 3'd0, 16'h0000, 3'd3, 3'd3, 3'd0, 3'd5, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h0, 16'h0);
    vecs[2]  = mkVec(0, 1, 3'd5, 16'hBEEF, 3'd5, 3'd3, 3'd5, 3'd0, 16'hBEEF, 16'h1234, 16'h0, 16'h1234, 16'h0, 16'h0);
    vecs[3]  = mkVec(0, 0, 3'd0, 16'h0000, 3'd5, 3'd5, 3'd5, 3'd3, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'h1234);
    vecs[4]  = mkVec(0, 1, 3'd0, 16'hFFFF, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    vecs[5]  = mkVec(0, 0, 3'd0, 16'h0000, 3'd0, 3'd5, 3'd0, 3'd0, 16'h0, 16'hBEEF, 16'h0, 16'hBEEF, 16'h0, 16'h0);
    vecs[6]  = mkVec(0, 1, 3'd7, 16'h0070, 3'd0, 3'd1, 3'd6, 3'd7, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    vecs[7]  = mkVec(0, 1, 3'd6, 16'h0060, 3'd0, 3'd1, 3'd6, 3'd7, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0070);
    vecs[8]  = mkVec(0, 1, 3'd1, 16'h0010, 3'd0, 3'd1, 3'd6, 3'd7, 16'h0, 16'h0010, 16'h0, 16'h0, 16'h0060, 16'h0070);
    vecs[9]  = mkVec(0, 0, 3'd0, 16'h0000, 3'd0, 3'd1, 3'd6, 3'd7, 16'h0, 16'h0010, 16'h0, 16'h0010, 16'h0060, 16'h0070);
    vecs[10] = mkVec(1, 1, 3'd3, 16'h5555, 3'd3, 3'd7, 3'd0, 3'd3, 16'h5555, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    vecs[11] = mkVec(0, 0, 3'd0, 16'h0000, 3'd3, 3'd7, 3'd0, 3'd1, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].we, vecs[i].wa, vecs[i].wd,
                    vecs[i].ra[0], vecs[i].ra[1], vecs[i].ra[2], vecs[i].ra[3]);
      for (int k = 0; k < 2; k++) begin
        checkOutput($sformatf("row%0d.a%0d", i, k), {48'h0, rdDataA[k*16 +: 16]}, {48'h0, vecs[i].ea[k]});
      end
      for (int k = 0; k < 4; k++) begin
        checkOutput($sformatf("row%0d.b%0d", i, k), {48'h0, rdDataB[k*16 +: 16]}, {48'h0, vecs[i].eb[k]});
      end
    end

`ifdef REGFILE_SCOREBOARD_EN
    // Issue to r2: not busy until the edge
    applyStimulus(1'b0, 1'b0, 3'd0, 16'h0, 3'd2, 3'd2, 3'd2, 3'd2);
    issValid = 1'b1; issDst = 3'd2; #1;
    checkOutput("sb.issue.busyA", {62'h0, rdBusyA}, 64'h0);
    applyStimulus(1'b0, 1'b0, 3'd0, 16'h0, 3'd2, 3'd4, 3'd2, 3'd4);
    issValid = 1'b0; #1;
    checkOutput("sb.pend.busyA", {62'h0, rdBusyA}, 64'h1);
    checkOutput("sb.pend.stallA", {63'h0, stallA}, 64'h1);
    checkOutput("sb.pend.busyB", {60'h0, rdBusyB}, 64'h5);

    // Write-back to r2: bypass masks busy in dutA only
    applyStimulus(1'b0, 1'b1, 3'd2, 16'h2222, 3'd2, 3'd2, 3'd2, 3'd2);
    checkOutput("sb.wb.busyA", {62'h0, rdBusyA}, 64'h0);
    checkOutput("sb.wb.stallA", {63'h0, stallA}, 64'h0);
    checkOutput("sb.wb.busyB", {60'h0, rdBusyB}, 64'hF);
    checkOutput("sb.wb.stallB", {63'h0, stallB}, 64'h1);
    applyStimulus(1'b0, 1'b0, 3'd0, 16'h0, 3'd2, 3'd2, 3'd2, 3'd2);
    checkOutput("sb.cleared.busyA", {62'h0, rdBusyA}, 64'h0);
    checkOutput("sb.cleared.busyB", {60'h0, rdBusyB}, 64'h0);

    // Simultaneous issue and write-back to r2: issue wins
    applyStimulus(1'b0, 1'b1, 3'd2, 16'h3333, 3'd4, 3'd4, 3'd4, 3'd4);
    issValid = 1'b1; issDst = 3'd2;
    applyStimulus(1'b0, 1'b0, 3'd0, 16'h0, 3'd2, 3'd2, 3'd2, 3'd2);
    issValid = 1'b0; #1;
    checkOutput("sb.setwins.busyA", {62'h0, rdBusyA}, 64'h3);
    checkOutput("sb.setwins.stallA", {63'h0, stallA}, 64'h1);

    // Issue to r0 never sets a busy bit
    applyStimulus(1'b0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 3'd0, 3'd0);
    issValid = 1'b1; issDst = 3'd0;
    applyStimulus(1'b0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 3'd0, 3'd0);
    issValid = 1'b0; #1;
    checkOutput("sb.r0.busyA", {62'h0, rdBusyA}, 64'h0);
    checkOutput("sb.r0.busyB", {60'h0, rdBusyB}, 64'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
